// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan controller and its SAR core.
package adc_scan_pkg;

    localparam int NCH_DEF = 18;
    localparam int DW_DEF  = 10;
    localparam int CHW     = 5;

    // Comparator mux channel indices (bit positions of cmp_sel)
    localparam int CH_VIN20 = 0;
    localparam int CH_VO10  = 1;
    localparam int CH_IS    = 2;
    localparam int CH_TS    = 3;
    localparam int CH_DP    = 4;
    localparam int CH_DN    = 5;
    localparam int CH_CC1   = 6;
    localparam int CH_CC2   = 7;
    localparam int CH_DP_3  = 8;
    localparam int CH_DN_3  = 9;
    localparam int CH_VO20  = 10;
    localparam int CH_CC1_4 = 11;
    localparam int CH_CC2_4 = 12;
    localparam int CH_GP5   = 13;
    localparam int CH_GP4   = 14;
    localparam int CH_GP3   = 15;
    localparam int CH_GP2   = 16;
    localparam int CH_GP1   = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIND,
        ST_SEL,
        ST_SAMPLE,
        ST_CONV,
        ST_STORE,
        ST_TRACK
    } scan_state_t;

    // A programmed settle count of zero still needs one cycle to settle.
    function automatic logic [3:0] eff_settle(input logic [3:0] s);
        return (s == 4'd0) ? 4'd1 : s;
    endfunction

endpackage

// File: rtl/adc_sar_core.sv
// Successive-approximation engine: comp_o synchronizer, trial/result registers,
// bit counter and per-trial settle counter. Runs one conversion per go pulse.
module adc_sar_core
    import adc_scan_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int SYNC_STG = 2
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          clr,
    input  logic          go,
    input  logic [3:0]    settle_cyc,
    input  logic          comp_o,
    output logic [DW-1:0] code,
    output logic [DW-1:0] result,
    output logic          done
);

    localparam int BW = $clog2(DW);

    logic [SYNC_STG-1:0] sync_reg;
    logic [DW-1:0]       code_reg, code_next;
    logic [BW-1:0]       bit_reg, bit_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [7:0]          len_reg, len_next;
    logic                active_reg, active_next;
    logic                comp_s;
    logic [7:0]          trial_len;

    assign comp_s = sync_reg[SYNC_STG-1];

    // Trial length minus one: settle time plus synchronizer latency
    assign trial_len = {4'd0, eff_settle(settle_cyc)} + 8'(SYNC_STG) - 8'd1;

    // Trial code with the current bit resolved by the comparator
    always_comb begin
        result          = code_reg;
        result[bit_reg] = comp_s;
    end

    assign done = active_reg && (cnt_reg == 8'd0) && (bit_reg == '0);
    assign code = code_reg;

    always_comb begin
        code_next   = code_reg;
        bit_next    = bit_reg;
        cnt_next    = cnt_reg;
        len_next    = len_reg;
        active_next = active_reg;
        if (clr) begin
            active_next = 1'b0;
        end else if (go) begin
            code_next         = '0;
            code_next[DW-1]   = 1'b1;
            bit_next          = BW'(DW - 1);
            cnt_next          = trial_len;
            len_next          = trial_len;
            active_next       = 1'b1;
        end else if (active_reg) begin
            if (cnt_reg != 8'd0) begin
                cnt_next = cnt_reg - 8'd1;
            end else begin
                code_next = result;
                if (bit_reg == '0) begin
                    active_next = 1'b0;
                end else begin
                    bit_next            = bit_reg - BW'(1);
                    code_next[bit_next] = 1'b1;
                    cnt_next            = len_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            sync_reg   <= '0;
            code_reg   <= '0;
            bit_reg    <= '0;
            cnt_reg    <= '0;
            len_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STG-2:0], comp_o};
            code_reg   <= code_next;
            bit_reg    <= bit_next;
            cnt_reg    <= cnt_next;
            len_reg    <= len_next;
            active_reg <= active_next;
        end
    end

endmodule

// File: rtl/adc_scan_ctl.sv
// Channel-scan controller for the shared SAR comparator: channel FSM and mask.
// Define ADC_AVG4_EN to average four conversions per channel.
module adc_scan_ctl
    import adc_scan_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int DW       = DW_DEF,
    parameter int SYNC_STG = 2
) (
    input  logic           clk,
    input  logic           rstz,
    input  logic           start,
    input  logic           stop,
    input  logic           continuous,
    input  logic [NCH-1:0] chan_en,
    input  logic [3:0]     settle_cyc,
    input  logic           comp_o,
    output logic           dac_en,
    output logic [DW-1:0]  dac_code,
    output logic           ad_rst,
    output logic           ad_hold,
    output logic [NCH-1:0] cmp_sel,
    output logic           busy,
    output logic           res_vld,
    output logic [4:0]     res_chan,
    output logic [DW-1:0]  res_data,
    output logic           scan_done
);

    scan_state_t    state_reg, state_next;
    logic [NCH-1:0] en_reg, en_next;
    logic [NCH-1:0] pend_reg, pend_next;
    logic [CHW-1:0] chan_reg, chan_next;
    logic [3:0]     sel_cnt_reg, sel_cnt_next;
    logic [CHW-1:0] res_chan_reg, res_chan_next;
    logic [DW-1:0]  res_data_reg, res_data_next;
    logic           done_reg, done_next;

    logic           core_go;
    logic           core_done;
    logic [DW-1:0]  core_code;
    logic [DW-1:0]  core_result;

    logic           found;
    logic [CHW-1:0] low_idx;
    logic           chan_act;

`ifdef ADC_AVG4_EN
    logic [1:0]     rep_reg, rep_next;
    logic [DW+1:0]  sum_reg, sum_next;
    logic [DW+1:0]  sum_acc;

    assign sum_acc = sum_reg + {2'b00, core_result};
`endif

    adc_sar_core #(
        .DW       (DW),
        .SYNC_STG (SYNC_STG)
    ) u_sar (
        .clk        (clk),
        .rstz       (rstz),
        .clr        (stop),
        .go         (core_go),
        .settle_cyc (settle_cyc),
        .comp_o     (comp_o),
        .code       (core_code),
        .result     (core_result),
        .done       (core_done)
    );

    // Lowest-index pending channel wins
    always_comb begin
        found   = 1'b0;
        low_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                found   = 1'b1;
                low_idx = CHW'(i);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        en_next       = en_reg;
        pend_next     = pend_reg;
        chan_next     = chan_reg;
        sel_cnt_next  = sel_cnt_reg;
        res_chan_next = res_chan_reg;
        res_data_next = res_data_reg;
        done_next     = 1'b0;
        core_go       = 1'b0;
`ifdef ADC_AVG4_EN
        rep_next      = rep_reg;
        sum_next      = sum_reg;
`endif
        if (stop) begin
            state_next    = ST_IDLE;
            res_chan_next = '0;
            res_data_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        en_next    = chan_en;
                        pend_next  = chan_en;
                        state_next = ST_FIND;
                    end
                end
                ST_FIND: begin
                    if (found) begin
                        chan_next    = low_idx;
                        sel_cnt_next = eff_settle(settle_cyc) - 4'd1;
                        state_next   = ST_SEL;
`ifdef ADC_AVG4_EN
                        rep_next     = 2'd0;
                        sum_next     = '0;
`endif
                    end else begin
                        done_next = 1'b1;
                        if (continuous) begin
                            pend_next = en_reg;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_SEL: begin
                    if (sel_cnt_reg == 4'd0) begin
                        state_next = ST_SAMPLE;
                    end else begin
                        sel_cnt_next = sel_cnt_reg - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    core_go    = 1'b1;
                    state_next = ST_CONV;
                end
                ST_CONV: begin
                    if (core_done) begin
`ifdef ADC_AVG4_EN
                        sum_next = sum_acc;
                        if (rep_reg == 2'd3) begin
                            res_data_next = sum_acc[DW+1:2];
                            res_chan_next = chan_reg;
                            state_next    = ST_STORE;
                        end else begin
                            rep_next   = rep_reg + 2'd1;
                            state_next = ST_TRACK;
                        end
`else
                        res_data_next = core_result;
                        res_chan_next = chan_reg;
                        state_next    = ST_STORE;
`endif
                    end
                end
                ST_STORE: begin
                    pend_next[chan_reg] = 1'b0;
                    state_next          = ST_FIND;
                end
`ifdef ADC_AVG4_EN
                // Re-track for one cycle between averaged conversions
                ST_TRACK: begin
                    state_next = ST_SAMPLE;
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_reg    <= ST_IDLE;
            en_reg       <= '0;
            pend_reg     <= '0;
            chan_reg     <= '0;
            sel_cnt_reg  <= '0;
            res_chan_reg <= '0;
            res_data_reg <= '0;
            done_reg     <= 1'b0;
`ifdef ADC_AVG4_EN
            rep_reg      <= '0;
            sum_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            en_reg       <= en_next;
            pend_reg     <= pend_next;
            chan_reg     <= chan_next;
            sel_cnt_reg  <= sel_cnt_next;
            res_chan_reg <= res_chan_next;
            res_data_reg <= res_data_next;
            done_reg     <= done_next;
`ifdef ADC_AVG4_EN
            rep_reg      <= rep_next;
            sum_reg      <= sum_next;
`endif
        end
    end

    // Outputs decode from registered state, so reset and stop clear them directly
    assign chan_act = state_reg inside {ST_SEL, ST_SAMPLE, ST_CONV, ST_STORE, ST_TRACK};

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_sel
            assign cmp_sel[gi] = chan_act && (chan_reg == CHW'(gi));
        end
    endgenerate

    assign busy      = (state_reg != ST_IDLE);
    assign dac_en    = chan_act;
    assign ad_rst    = (state_reg == ST_SEL) || (state_reg == ST_TRACK);
    assign ad_hold   = (state_reg == ST_SAMPLE) || (state_reg == ST_CONV);
    assign dac_code  = ((state_reg == ST_CONV) || (state_reg == ST_STORE)) ? core_code : '0;
    assign res_vld   = (state_reg == ST_STORE);
    assign res_chan  = res_chan_reg;
    assign res_data  = res_data_reg;
    assign scan_done = done_reg;

endmodule

// File: tb/tb_adc_scan_ctl.sv
// Directed/randomized bench for adc_scan_ctl with a per-channel analog input model.
module tb_adc_scan_ctl;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [17:0] chan_en = '0;
    logic [3:0]  settle_cyc = 4'd1;
    logic        comp_o;
    logic        dac_en;
    logic [9:0]  dac_code;
    logic        ad_rst;
    logic        ad_hold;
    logic [17:0] cmp_sel;
    logic        busy;
    logic        res_vld;
    logic [4:0]  res_chan;
    logic [9:0]  res_data;
    logic        scan_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int vin [18];
    bit alt = 1'b0;
    bit rep_par = 1'b0;
    logic hold_d = 1'b0;

    adc_scan_ctl dut (
        .clk        (clk),
        .rstz       (rstz),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .chan_en    (chan_en),
        .settle_cyc (settle_cyc),
        .comp_o     (comp_o),
        .dac_en     (dac_en),
        .dac_code   (dac_code),
        .ad_rst     (ad_rst),
        .ad_hold    (ad_hold),
        .cmp_sel    (cmp_sel),
        .busy       (busy),
        .res_vld    (res_vld),
        .res_chan   (res_chan),
        .res_data   (res_data),
        .scan_done  (scan_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Analog input may step by one LSB between averaged repeats
    always @(posedge clk) begin
        hold_d <= ad_hold;
        if (start) rep_par <= 1'b0;
        else if (hold_d && !ad_hold) rep_par <= ~rep_par;
    end

    function automatic int sel_idx(input logic [17:0] v);
        for (int i = 0; i < 18; i++) if (v[i]) return i;
        return 0;
    endfunction

    assign comp_o = dac_en && ((vin[sel_idx(cmp_sel)] + (alt ? int'(rep_par) : 0)) >= int'(dac_code));

    function automatic int clampv(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    // Expected result: the largest code the comparator accepts (averaged if enabled)
    function automatic int exp_code(input int ch);
`ifdef ADC_AVG4_EN
        int s = 0;
        for (int r = 0; r < 4; r++) s += clampv(vin[ch] + (alt ? (r % 2) : 0));
        return s / 4;
`else
        return clampv(vin[ch]);
`endif
    endfunction

    function automatic int chan_cycles(input int s);
`ifdef ADC_AVG4_EN
        return s + 4 * (1 + 10 * (s + 2)) + 3 + 1;
`else
        return s + 1 + 10 * (s + 2) + 1;
`endif
    endfunction

    function automatic int hold_cycles(input int s);
`ifdef ADC_AVG4_EN
        return 4 * (1 + 10 * (s + 2));
`else
        return 1 + 10 * (s + 2);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_ctl"}, 32'({busy, dac_en, ad_rst, ad_hold, res_vld, scan_done}), 32'd0);
        chk({tag, "_sel"}, 32'(cmp_sel), 32'd0);
        chk({tag, "_code"}, 32'(dac_code), 32'd0);
        chk({tag, "_res"}, 32'({res_chan, res_data}), 32'd0);
    endtask

    task automatic run_scan(input logic [17:0] mask, input logic [3:0] s, input bit poke);
        int se, p, n, t0, k, got, hold_n, dac_bad;
        int q_ch[$];
        int q_d[$];
        logic [17:0] one_hot;
        se = (s == 4'd0) ? 1 : int'(s);
        p  = 1 + chan_cycles(se);
        for (int i = 0; i < 18; i++) begin
            if (mask[i]) begin
                q_ch.push_back(i);
                q_d.push_back(exp_code(i));
            end
        end
        n = q_ch.size();
        settle_cyc = s;
        chan_en = mask;
        @(posedge clk); #1 start = 1'b1; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        got = 0; k = 0; hold_n = 0; dac_bad = 0;
        for (int c = 0; c < 20000 && got == 0; c++) begin
            @(negedge clk);
            if (poke && c == 20) begin start = 1'b1; chan_en = ~mask; end
            if (poke && c == 21) start = 1'b0;
            if (ad_hold) hold_n++;
            if (!ad_hold && !res_vld && dac_code != 10'd0) dac_bad++;
            if (res_vld) begin
                if (k < n) begin
                    one_hot = 18'd1 << q_ch[k];
                    chk("res_chan", 32'(res_chan), 32'(q_ch[k]));
                    chk("res_data", 32'(res_data), 32'(q_d[k]));
                    chk("cmp_sel", 32'(cmp_sel), 32'(one_hot));
                    chk("res_latency", cyc - t0, (k + 1) * p);
`ifndef ADC_AVG4_EN
                    chk("store_code", 32'(dac_code), 32'(q_d[k]));
`endif
                end
                k++;
            end
            if (scan_done) begin
                got = 1;
                chk("done_latency", cyc - t0, n * p + 2);
            end
        end
        chk("done_seen", got, 1);
        chk("res_count", k, n);
        chk("hold_cycles", hold_n, n * hold_cycles(se));
        chk("dac_zero_outside_conv", dac_bad, 0);
        @(negedge clk);
        chk("busy_after_scan", 32'(busy), 32'd0);
        $display("scan mask=%05h S=%0d poke=%0d results=%0d", mask, s, poke, k);
    endtask

    initial begin
        int t0, prev, nres, ndone, got, bad;
        for (int i = 0; i < 18; i++) vin[i] = int'($urandom_range(0, 1023));

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk); idle_check("reset");
        @(posedge clk); #1 rstz = 1'b1;
        @(negedge clk); idle_check("post_reset");

        // Single channel, thresholds 600 / all-ones / all-zeros
        vin[0] = 600;  run_scan(18'h00001, 4'd1, 1'b0);
        vin[0] = 2000; run_scan(18'h00001, 4'd1, 1'b0);
        vin[0] = -1;   run_scan(18'h00001, 4'd1, 1'b0);

        // Two channels, empty mask, settle of zero, start while busy
        run_scan(18'h20008, 4'd1, 1'b0);
        run_scan(18'h00000, 4'd1, 1'b0);
        run_scan(18'h00005, 4'd0, 1'b0);
        run_scan(18'h00102, 4'd2, 1'b1);

        // Stop during a bit trial
        vin[0] = 600; settle_cyc = 4'd1; chan_en = 18'h00001;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 chk("stop_pre_hold", 32'(ad_hold), 32'd1);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk); idle_check("stop");
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (res_vld || scan_done || busy) bad++;
        end
        chk("stop_quiet", bad, 0);
        $display("stop mid-conversion checked");
        run_scan(18'h00001, 4'd1, 1'b0);

        // Stop and start together
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        @(negedge clk); chk("stop_beats_start", 32'(busy), 32'd0);
        $display("stop+start checked");

        // Continuous mode on channel 2
        vin[2] = int'($urandom_range(0, 1023));
        settle_cyc = 4'd1; chan_en = 18'h00004; continuous = 1'b1;
        @(posedge clk); #1 start = 1'b1; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        prev = -1; nres = 0; ndone = 0;
        for (int c = 0; c < 400 && nres < 3; c++) begin
            @(negedge clk);
            if (scan_done) ndone++;
            if (res_vld) begin
                chk("cont_chan", 32'(res_chan), 32'd2);
                chk("cont_data", 32'(res_data), 32'(exp_code(2)));
                if (prev >= 0) chk("cont_spacing", cyc - prev, chan_cycles(1) + 2);
                prev = cyc;
                nres++;
            end
        end
        continuous = 1'b0;
        chk("cont_results", nres, 3);
        chk("cont_dones", ndone, 2);
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (scan_done) got = 1;
        end
        chk("cont_final_done", got, 1);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (res_vld || busy) bad++;
        end
        chk("cont_stopped", bad, 0);
        $display("continuous scan results=%0d", nres);

        // Asynchronous reset in the middle of a conversion
        chan_en = 18'h00001;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #3 rstz = 1'b0;
        #1 idle_check("async_reset");
        @(posedge clk); #1 rstz = 1'b1;
        $display("async reset checked");
        run_scan(18'h00001, 4'd1, 1'b0);

        // Randomized masks, settle counts and inputs
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < 18; i++) vin[i] = int'($urandom_range(0, 1023));
            run_scan(18'($urandom), 4'($urandom_range(0, 3)), 1'b0);
        end

`ifdef ADC_AVG4_EN
        alt = 1'b1; vin[0] = 600;
        run_scan(18'h00001, 4'd1, 1'b0);
        alt = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
